// File: rtl/ocd_frame_rx_if.sv
// Debug frame receiver bus: UART byte strobe in, assembled frame and error status out.
// master = receiver (ocd_frame_rx), slave = byte source / frame consumer.
interface ocd_frame_rx_if #(
    parameter int unsigned PAYLOAD_BYTES = 4
);
    logic                         rx_valid;
    logic [7:0]                   rx_data;
    logic                         frame_valid;
    logic                         frame_ready;
    logic [7:0]                   frame_cmd;
    logic [8*PAYLOAD_BYTES-1:0]   frame_payload;
    logic                         err_pulse;
    logic [1:0]                   err_code;
    logic                         busy;

    modport master (
        input  rx_valid, rx_data, frame_ready,
        output frame_valid, frame_cmd, frame_payload, err_pulse, err_code, busy
    );

    modport slave (
        output rx_valid, rx_data, frame_ready,
        input  frame_valid, frame_cmd, frame_payload, err_pulse, err_code, busy
    );
endinterface

// File: rtl/ocd_frame_rx.sv
// On-chip-debugger frame receiver: sync hunt, cmd + payload assembly, timeout/overflow detection.
// Define OCD_FRAME_CHECKSUM_EN to require a trailing mod-256 checksum byte per frame.
module ocd_frame_rx #(
    parameter int unsigned PAYLOAD_BYTES  = 4,
    parameter logic [7:0]  SYNC0          = 8'h5A,
    parameter logic [7:0]  SYNC1          = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input logic             clk,
    input logic             reset_n,
    ocd_frame_rx_if.master  bus
);
    localparam int unsigned PW = 8 * PAYLOAD_BYTES;
    localparam int unsigned CW = $clog2(PAYLOAD_BYTES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(PAYLOAD_BYTES - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd3;
`ifdef OCD_FRAME_CHECKSUM_EN
    localparam logic [1:0] ERR_CHECKSUM = 2'd2;
`endif

    typedef enum logic [2:0] {
        S_SYNC0   = 3'd0,
        S_SYNC1   = 3'd1,
        S_CMD     = 3'd2,
        S_PAYLOAD = 3'd3
`ifdef OCD_FRAME_CHECKSUM_EN
        ,S_CHK    = 3'd4
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [7:0]      cmd_sh_q, cmd_sh_d;
    logic [PW-1:0]   pay_sh_q, pay_sh_d;
    logic            fv_q, fv_d;
    logic [7:0]      fcmd_q, fcmd_d;
    logic [PW-1:0]   fpay_q, fpay_d;
    logic            err_pulse_q, err_pulse_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            busy_q, busy_d;
    logic            complete;
`ifdef OCD_FRAME_CHECKSUM_EN
    logic [7:0]      sum_q, sum_d;
`endif

    // Next-state, shadow assembly and output update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        cmd_sh_d    = cmd_sh_q;
        pay_sh_d    = pay_sh_q;
        fv_d        = fv_q;
        fcmd_d      = fcmd_q;
        fpay_d      = fpay_q;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        complete    = 1'b0;
`ifdef OCD_FRAME_CHECKSUM_EN
        sum_d       = sum_q;
`endif

        if (fv_q && bus.frame_ready) begin
            fv_d = 1'b0;
        end

        // Inter-byte timeout; a byte in the limit cycle pre-empts it.
        if (state_q == S_SYNC0 || bus.rx_valid) begin
            tmo_d = '0;
        end else if (tmo_q == TMAX) begin
            tmo_d       = '0;
            state_d     = S_SYNC0;
            err_pulse_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        if (bus.rx_valid) begin
            case (state_q)
                S_SYNC0: begin
                    if (bus.rx_data == SYNC0) state_d = S_SYNC1;
                end
                S_SYNC1: begin
                    if (bus.rx_data == SYNC1)      state_d = S_CMD;
                    else if (bus.rx_data != SYNC0) state_d = S_SYNC0;
                end
                S_CMD: begin
                    cmd_sh_d = bus.rx_data;
                    cnt_d    = '0;
                    state_d  = S_PAYLOAD;
`ifdef OCD_FRAME_CHECKSUM_EN
                    sum_d    = bus.rx_data;
`endif
                end
                S_PAYLOAD: begin
                    pay_sh_d = PW'({pay_sh_q, bus.rx_data});
`ifdef OCD_FRAME_CHECKSUM_EN
                    sum_d    = 8'(sum_q + bus.rx_data);
`endif
                    if (cnt_q == LAST) begin
`ifdef OCD_FRAME_CHECKSUM_EN
                        state_d  = S_CHK;
`else
                        state_d  = S_SYNC0;
                        complete = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
`ifdef OCD_FRAME_CHECKSUM_EN
                S_CHK: begin
                    state_d = S_SYNC0;
                    if (8'(sum_q + bus.rx_data) == 8'h00) begin
                        complete = 1'b1;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_code_d  = ERR_CHECKSUM;
                    end
                end
`endif
                default: state_d = S_SYNC0;
            endcase
        end

        // A held, unaccepted frame makes the new one an overflow.
        if (complete) begin
            if (!fv_q || bus.frame_ready) begin
                fv_d   = 1'b1;
                fcmd_d = cmd_sh_d;
                fpay_d = pay_sh_d;
            end else begin
                err_pulse_d = 1'b1;
                err_code_d  = ERR_OVERFLOW;
            end
        end

        busy_d = (state_d != S_SYNC0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_SYNC0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            cmd_sh_q    <= '0;
            pay_sh_q    <= '0;
            fv_q        <= 1'b0;
            fcmd_q      <= '0;
            fpay_q      <= '0;
            err_pulse_q <= 1'b0;
            err_code_q  <= '0;
            busy_q      <= 1'b0;
`ifdef OCD_FRAME_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            cmd_sh_q    <= cmd_sh_d;
            pay_sh_q    <= pay_sh_d;
            fv_q        <= fv_d;
            fcmd_q      <= fcmd_d;
            fpay_q      <= fpay_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            busy_q      <= busy_d;
`ifdef OCD_FRAME_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign bus.frame_valid   = fv_q;
    assign bus.frame_cmd     = fcmd_q;
    assign bus.frame_payload = fpay_q;
    assign bus.err_pulse     = err_pulse_q;
    assign bus.err_code      = err_code_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_ocd_frame_rx.sv
// Directed bench for ocd_frame_rx (4 payload bytes, 50-cycle timeout): vector table plus
// hand sequences for timeout, reset mid-frame and checksum handling.
module tb_ocd_frame_rx;
    localparam int unsigned PB  = 4;
    localparam int unsigned TMO = 50;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ocd_frame_rx_if #(.PAYLOAD_BYTES(PB)) bus ();

    ocd_frame_rx #(
        .PAYLOAD_BYTES  (PB),
        .SYNC0          (8'h5A),
        .SYNC1          (8'hA5),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        r;
        logic        fv;
        logic [7:0]  cmd;
        logic [31:0] pay;
        logic        ep;
        logic [1:0]  ec;
        logic        bz;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic add(input logic v, input logic [7:0] d, input logic r,
                       input logic fv, input logic [7:0] cmd, input logic [31:0] pay,
                       input logic ep, input logic [1:0] ec, input logic bz);
        vec_t t;
        t.v = v; t.d = d; t.r = r; t.fv = fv; t.cmd = cmd; t.pay = pay;
        t.ep = ep; t.ec = ec; t.bz = bz;
        vecs.push_back(t);
    endtask

    // One clock: inputs change on the falling edge, outputs sampled 1ns after the rising edge.
    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        @(negedge clk);
        bus.rx_valid    = v;
        bus.rx_data     = d;
        bus.frame_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic fv, input logic [7:0] cmd,
                       input logic [31:0] pay, input logic ep, input logic [1:0] ec,
                       input logic bz);
        n_vec++;
        if (bus.frame_valid !== fv || bus.frame_cmd !== cmd || bus.frame_payload !== pay ||
            bus.err_pulse !== ep || bus.err_code !== ec || bus.busy !== bz) begin
            n_miss++;
            $display("FAIL %s: got fv=%b cmd=%h pay=%h err=%b code=%0d busy=%b, want fv=%b cmd=%h pay=%h err=%b code=%0d busy=%b",
                     name, bus.frame_valid, bus.frame_cmd, bus.frame_payload, bus.err_pulse,
                     bus.err_code, bus.busy, fv, cmd, pay, ep, ec, bz);
        end
    endtask

    // Full frame from sync to last byte (checksum byte appended when enabled).
    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] pay);
        logic [7:0] b;
        logic [7:0] sum;
        drive(1'b1, 8'h5A, 1'b1);
        drive(1'b1, 8'hA5, 1'b1);
        drive(1'b1, cmd, 1'b1);
        sum = cmd;
        for (int i = 3; i >= 0; i--) begin
            b = pay[8*i +: 8];
            sum = 8'(sum + b);
            drive(1'b1, b, 1'b1);
        end
`ifdef OCD_FRAME_CHECKSUM_EN
        drive(1'b1, 8'(8'h00 - sum), 1'b1);
`endif
    endtask

    logic [7:0]  ecmd;
    logic [31:0] epay;
    logic [1:0]  ecode;
    int          k;

    initial begin
        bus.rx_valid    = 1'b0;
        bus.rx_data     = 8'h00;
        bus.frame_ready = 1'b0;

`ifndef OCD_FRAME_CHECKSUM_EN
        // Basic frame
        add(1,8'h5A,1, 0,8'h00,32'h0,0,0,1);
        add(1,8'hA5,1, 0,8'h00,32'h0,0,0,1);
        add(1,8'h03,1, 0,8'h00,32'h0,0,0,1);
        add(1,8'h11,1, 0,8'h00,32'h0,0,0,1);
        add(1,8'h22,1, 0,8'h00,32'h0,0,0,1);
        add(1,8'h33,1, 0,8'h00,32'h0,0,0,1);
        add(1,8'h44,1, 1,8'h03,32'h11223344,0,0,0);
        add(0,8'h00,1, 0,8'h03,32'h11223344,0,0,0);
        // Unstrobed data ignored; bad second sync byte aborts silently
        add(0,8'h5A,1, 0,8'h03,32'h11223344,0,0,0);
        add(1,8'h5A,1, 0,8'h03,32'h11223344,0,0,1);
        add(1,8'h77,1, 0,8'h03,32'h11223344,0,0,0);
        // Resync on repeated SYNC0, consumer stalled
        add(1,8'h5A,0, 0,8'h03,32'h11223344,0,0,1);
        add(1,8'h5A,0, 0,8'h03,32'h11223344,0,0,1);
        add(1,8'hA5,0, 0,8'h03,32'h11223344,0,0,1);
        add(1,8'h07,0, 0,8'h03,32'h11223344,0,0,1);
        add(1,8'h01,0, 0,8'h03,32'h11223344,0,0,1);
        add(1,8'h02,0, 0,8'h03,32'h11223344,0,0,1);
        add(1,8'h03,0, 0,8'h03,32'h11223344,0,0,1);
        add(1,8'h04,0, 1,8'h07,32'h01020304,0,0,0);
        // Second frame while first is held: overflow
        add(1,8'h5A,0, 1,8'h07,32'h01020304,0,0,1);
        add(1,8'hA5,0, 1,8'h07,32'h01020304,0,0,1);
        add(1,8'h09,0, 1,8'h07,32'h01020304,0,0,1);
        add(1,8'hAA,0, 1,8'h07,32'h01020304,0,0,1);
        add(1,8'hBB,0, 1,8'h07,32'h01020304,0,0,1);
        add(1,8'hCC,0, 1,8'h07,32'h01020304,0,0,1);
        add(1,8'hDD,0, 1,8'h07,32'h01020304,1,3,0);
        add(0,8'h00,0, 1,8'h07,32'h01020304,0,3,0);
        // Frame completes in the handshake cycle: valid stays high with new data
        add(1,8'h5A,0, 1,8'h07,32'h01020304,0,3,1);
        add(1,8'hA5,0, 1,8'h07,32'h01020304,0,3,1);
        add(1,8'h0B,0, 1,8'h07,32'h01020304,0,3,1);
        add(1,8'hF1,0, 1,8'h07,32'h01020304,0,3,1);
        add(1,8'hF2,0, 1,8'h07,32'h01020304,0,3,1);
        add(1,8'hF3,0, 1,8'h07,32'h01020304,0,3,1);
        add(1,8'hF4,1, 1,8'h0B,32'hF1F2F3F4,0,3,0);
        add(0,8'h00,1, 0,8'h0B,32'hF1F2F3F4,0,3,0);
        ecmd = 8'h0B; epay = 32'hF1F2F3F4; ecode = 2'd3;
`else
        // Good checksum: 01+01+FE = 0x100
        add(1,8'h5A,1, 0,8'h00,32'h0,0,0,1);
        add(1,8'hA5,1, 0,8'h00,32'h0,0,0,1);
        add(1,8'h01,1, 0,8'h00,32'h0,0,0,1);
        add(1,8'h00,1, 0,8'h00,32'h0,0,0,1);
        add(1,8'h00,1, 0,8'h00,32'h0,0,0,1);
        add(1,8'h00,1, 0,8'h00,32'h0,0,0,1);
        add(1,8'h01,1, 0,8'h00,32'h0,0,0,1);
        add(1,8'hFE,1, 1,8'h01,32'h00000001,0,0,0);
        add(0,8'h00,1, 0,8'h01,32'h00000001,0,0,0);
        // Bad checksum: dropped with code 2
        add(1,8'h5A,1, 0,8'h01,32'h00000001,0,0,1);
        add(1,8'hA5,1, 0,8'h01,32'h00000001,0,0,1);
        add(1,8'h02,1, 0,8'h01,32'h00000001,0,0,1);
        add(1,8'h00,1, 0,8'h01,32'h00000001,0,0,1);
        add(1,8'h00,1, 0,8'h01,32'h00000001,0,0,1);
        add(1,8'h00,1, 0,8'h01,32'h00000001,0,0,1);
        add(1,8'h01,1, 0,8'h01,32'h00000001,0,0,1);
        add(1,8'hFF,1, 0,8'h01,32'h00000001,1,2,0);
        add(0,8'h00,1, 0,8'h01,32'h00000001,0,2,0);
        ecmd = 8'h01; epay = 32'h00000001; ecode = 2'd2;
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 0, 8'h00, 32'h0, 0, 2'd0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].r);
            chk($sformatf("vec%0d", i), vecs[i].fv, vecs[i].cmd, vecs[i].pay,
                vecs[i].ep, vecs[i].ec, vecs[i].bz);
        end

        // Byte arriving in the very cycle the timeout would fire wins.
        drive(1'b1, 8'h5A, 1'b1);
        repeat (TMO) drive(1'b0, 8'h00, 1'b1);
        drive(1'b1, 8'hA5, 1'b1);
        chk("tmo_rx_wins", 0, ecmd, epay, 0, ecode, 1);

        // Idle after a partial frame: pulse 51 clocks after the last strobe.
        drive(1'b1, 8'h03, 1'b1);
        drive(1'b1, 8'h11, 1'b1);
        k = 0;
        for (int c = 1; c <= 80; c++) begin
            drive(1'b0, 8'h00, 1'b1);
            if (bus.err_pulse === 1'b1) begin
                k = c;
                break;
            end
        end
        n_vec++;
        if (k != TMO + 1) begin
            n_miss++;
            $display("FAIL tmo_latency: got %0d clocks, want %0d", k, TMO + 1);
        end
        chk("tmo_pulse", 0, ecmd, epay, 1, 2'd1, 0);
        drive(1'b0, 8'h00, 1'b1);
        chk("tmo_after", 0, ecmd, epay, 0, 2'd1, 0);

        send_frame(8'h21, 32'hDEADBEEF);
        chk("post_tmo_frame", 1, 8'h21, 32'hDEADBEEF, 0, 2'd1, 0);
        drive(1'b0, 8'h00, 1'b1);
        chk("post_tmo_drop", 0, 8'h21, 32'hDEADBEEF, 0, 2'd1, 0);

        // Reset mid-frame clears everything asynchronously.
        drive(1'b1, 8'h5A, 1'b0);
        drive(1'b1, 8'hA5, 1'b0);
        drive(1'b1, 8'h03, 1'b0);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("reset_mid", 0, 8'h00, 32'h0, 0, 2'd0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        send_frame(8'h42, 32'h10203040);
        chk("post_reset_frame", 1, 8'h42, 32'h10203040, 0, 2'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
